// File: rtl/pcap_replay_scheduler.sv
// Timestamp-paced packet release for the pcap replay path: holds each packet until the
// local microsecond time base reaches its record timestamp, then forwards incl_len octets.
module pcap_replay_scheduler #(
  parameter int DATA_WIDTH    = 64,
  parameter int CYCLES_PER_US = 156
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  logic                    pace_en,
  input  logic                    s_hdr_tvalid,
  output logic                    s_hdr_tready,
  input  logic [31:0]             s_hdr_ts_sec,
  input  logic [31:0]             s_hdr_ts_usec,
  input  logic [31:0]             s_hdr_incl_len,
  input  logic                    s_data_tvalid,
  output logic                    s_data_tready,
  input  logic [DATA_WIDTH/8-1:0] s_data_tstrb,
  input  logic [DATA_WIDTH-1:0]   s_data_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_WIDTH/8-1:0] m_tstrb,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tlast,
  output logic [31:0]             pkt_count,
  output logic                    late
);

  localparam int B     = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(B);
  localparam int PW    = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND} state_t;

  state_t           state_q;
  logic             started_q, started_d;
  logic [31:0]      now_sec_q, now_sec_d;
  logic [31:0]      now_usec_q, now_usec_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [31:0]      ts_sec_q, ts_usec_q;
  logic [LOG2B-1:0] rem_q;
  logic [32:0]      beats_q;
  logic [31:0]      pkt_count_q;
  logic             late_q;

  logic             hdr_fire, in_send, beat_fire, last_beat, due, late_now, presc_wrap;
  logic [32:0]      hdr_beats;
  logic [64:0]      ts_next;
  logic [B-1:0]     tail_mask;

  assign hdr_fire   = s_hdr_tvalid & s_hdr_tready;
  assign in_send    = (state_q == ST_SEND);
  assign beat_fire  = in_send & s_data_tvalid & m_tready;
  assign last_beat  = (beats_q == 33'd1);
  assign hdr_beats  = ({1'b0, s_hdr_incl_len} + 33'(B - 1)) >> LOG2B;
  assign presc_wrap = (presc_q == PW'(CYCLES_PER_US - 1));
  assign due        = !pace_en || ({now_sec_q, now_usec_q} >= {ts_sec_q, ts_usec_q});

  // Lateness threshold is ts + 1 us; the 33-bit seconds field keeps a ts_sec wrap from reading as late.
  assign ts_next  = (ts_usec_q == 32'd999999) ? {({1'b0, ts_sec_q} + 33'd1), 32'd0}
                                              : {1'b0, ts_sec_q, ts_usec_q + 32'd1};
  assign late_now = ({1'b0, now_sec_q, now_usec_q} > ts_next);

  always_comb begin
    tail_mask = '1;
    if (rem_q != '0) tail_mask = (B'(1) << rem_q) - B'(1);
  end

  assign s_hdr_tready  = aresetn & enable & (state_q == ST_IDLE);
  assign s_data_tready = in_send & m_tready;
  assign m_tvalid      = in_send & s_data_tvalid;
  assign m_tdata       = in_send ? s_data_tdata : '0;
  assign m_tlast       = in_send & last_beat;
  assign m_tstrb       = !in_send ? '0 : (last_beat ? (s_data_tstrb & tail_mask) : s_data_tstrb);
  assign pkt_count     = pkt_count_q;
  assign late          = late_q;

  // The time base starts from the first accepted timestamp, then free-runs while enabled.
  always_comb begin
    started_d  = started_q;
    now_sec_d  = now_sec_q;
    now_usec_d = now_usec_q;
    presc_d    = presc_q;
    if (hdr_fire && !started_q) begin
      started_d  = 1'b1;
      now_sec_d  = s_hdr_ts_sec;
      now_usec_d = s_hdr_ts_usec;
      presc_d    = '0;
    end else if (started_q && enable) begin
      if (presc_wrap) begin
        presc_d = '0;
        if (now_usec_q == 32'd999999) begin
          now_usec_d = '0;
          now_sec_d  = now_sec_q + 32'd1;
        end else begin
          now_usec_d = now_usec_q + 32'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      started_q  <= 1'b0;
      now_sec_q  <= '0;
      now_usec_q <= '0;
      presc_q    <= '0;
    end else begin
      started_q  <= started_d;
      now_sec_q  <= now_sec_d;
      now_usec_q <= now_usec_d;
      presc_q    <= presc_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      ts_sec_q    <= '0;
      ts_usec_q   <= '0;
      rem_q       <= '0;
      beats_q     <= '0;
      pkt_count_q <= '0;
      late_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_fire) begin
            ts_sec_q  <= s_hdr_ts_sec;
            ts_usec_q <= s_hdr_ts_usec;
            rem_q     <= s_hdr_incl_len[LOG2B-1:0];
            beats_q   <= hdr_beats;
            if (s_hdr_incl_len == 32'd0) pkt_count_q <= pkt_count_q + 32'd1;
            else                         state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (due) begin
            state_q <= ST_SEND;
            if (late_now) late_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (beat_fire) begin
            beats_q <= beats_q - 33'd1;
            if (last_beat) begin
              pkt_count_q <= pkt_count_q + 32'd1;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
